// File: rtl/sram_ifmap_ctrl_pkg.sv
// Shared types and sizes for the ifmap SRAM sequencer.
// Imported by the interface, address generator and controller.
package ifmap_pkg;

    localparam int IFMAP_ADDR_W = 12;
    localparam int IFMAP_DEPTH  = 4096;
    localparam int IFMAP_LEN_W  = 13;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        DONE
    } ctrl_state_e;

    typedef logic [7:0] byte_t;

    function automatic logic [IFMAP_LEN_W-1:0] clamp_len(
        input logic [IFMAP_LEN_W-1:0] l
    );
        if (l > IFMAP_LEN_W'(IFMAP_DEPTH))
            return IFMAP_LEN_W'(IFMAP_DEPTH);
        return l;
    endfunction

endpackage

// File: rtl/sram_ifmap_ctrl_if.sv
// Input stream, output stream and SRAM port bundle.
// master = controller side, slave = environment side.
interface sram_ifmap_ctrl_if;
    import ifmap_pkg::*;

    logic                    in_valid;
    logic [31:0]             in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic [63:0]             out_data;
    logic                    out_ready;
    logic                    sram_en;
    logic                    sram_we;
    logic [IFMAP_ADDR_W-1:0] sram_addr;
    logic [31:0]             sram_di;
    byte_t                   sram_do [0:7];

    modport master (
        input  in_valid, in_data, out_ready, sram_do,
        output in_ready, out_valid, out_data,
        output sram_en, sram_we, sram_addr, sram_di
    );

    modport slave (
        output in_valid, in_data, out_ready, sram_do,
        input  in_ready, out_valid, out_data,
        input  sram_en, sram_we, sram_addr, sram_di
    );

endinterface

// File: rtl/sram_ifmap_ctrl_addr_gen.sv
// Base/length latch with a step counter producing wrapped addresses.
// last_o flags the final address of the programmed run.
module ifmap_addr_gen
    import ifmap_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [IFMAP_ADDR_W-1:0] base_i,
    input  logic [IFMAP_LEN_W-1:0]  len_i,
    input  logic                    step_i,
    output logic [IFMAP_ADDR_W-1:0] addr_o,
    output logic                    last_o
);

    logic [IFMAP_ADDR_W-1:0] base_q, base_d;
    logic [IFMAP_LEN_W-1:0]  len_q, len_d;
    logic [IFMAP_LEN_W-1:0]  cnt_q, cnt_d;

    // Next-state: latch a new command or advance the counter.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = clamp_len(len_i);
            cnt_d  = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = base_q + cnt_q[IFMAP_ADDR_W-1:0];
    assign last_o = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/sram_ifmap_ctrl.sv
// ifmap SRAM sequencer: streams words in (LOAD), then
// issues reads and forwards 8-byte results (READ/DRAIN).
module sram_ifmap_ctrl
    import ifmap_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [IFMAP_ADDR_W-1:0] load_base,
    input  logic [IFMAP_LEN_W-1:0]  load_len,
    input  logic [IFMAP_ADDR_W-1:0] rd_base,
    input  logic [IFMAP_LEN_W-1:0]  rd_len,
    output logic                    busy,
    output logic                    done,
    sram_ifmap_ctrl_if.master       bus
);

    ctrl_state_e state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        rd_nz_q, rd_nz_d;

    logic                    cmd_load;
    logic                    w_step, r_step;
    logic                    w_last, r_last;
    logic [IFMAP_ADDR_W-1:0] w_addr, r_addr;
    logic                    in_ready;
    logic                    en, we;
    logic [IFMAP_ADDR_W-1:0] addr;
    logic [31:0]             di;

    ifmap_addr_gen u_wgen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (cmd_load),
        .base_i (load_base),
        .len_i  (load_len),
        .step_i (w_step),
        .addr_o (w_addr),
        .last_o (w_last)
    );

    ifmap_addr_gen u_rgen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (cmd_load),
        .base_i (rd_base),
        .len_i  (rd_len),
        .step_i (r_step),
        .addr_o (r_addr),
        .last_o (r_last)
    );

    // Next-state and SRAM/handshake outputs per state.
    always_comb begin
        state_d  = state_q;
        cmd_load = 1'b0;
        in_ready = 1'b0;
        en       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        di       = '0;
        w_step   = 1'b0;
        r_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_load = 1'b1;
                    if (load_len != '0)
                        state_d = LOAD;
                    else if (rd_len != '0)
                        state_d = READ;
                    else
                        state_d = DONE;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    we     = 1'b1;
                    addr   = w_addr;
                    di     = bus.in_data;
                    w_step = 1'b1;
                    if (w_last)
                        state_d = rd_nz_q ? READ : DONE;
                end
            end
            READ: begin
                if (!out_valid_q || bus.out_ready) begin
                    en     = 1'b1;
                    addr   = r_addr;
                    r_step = 1'b1;
                    if (r_last)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result-valid tracking and latched read-run flag.
    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        if (en)
            out_valid_d = 1'b1;
        rd_nz_d = rd_nz_q;
        if (cmd_load)
            rd_nz_d = (rd_len != '0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rd_nz_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rd_nz_q     <= rd_nz_d;
        end
    end

    // Byte j of the SRAM read port lands at bits [8j+7:8j].
    always_comb begin
        bus.out_data = '0;
        for (int j = 0; j < 8; j++)
            bus.out_data[8*j +: 8] = bus.sram_do[j];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sram_en   = en;
    assign bus.sram_we   = we;
    assign bus.sram_addr = addr;
    assign bus.sram_di   = di;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_sram_ifmap_ctrl.sv
// Directed bench for sram_ifmap_ctrl with a behavioural
// SRAM (registered 8-byte read of word addr and addr+1).
module tb_sram_ifmap_ctrl;
    import ifmap_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [11:0] load_base;
    logic [12:0] load_len;
    logic [11:0] rd_base;
    logic [12:0] rd_len;
    logic        busy;
    logic        done;

    int npass  = 0;
    int ntotal = 0;

    sram_ifmap_ctrl_if bus ();

    sram_ifmap_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .load_base (load_base),
        .load_len  (load_len),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:4095];

    always @(posedge CLK) begin
        logic [11:0] a1;
        if (bus.sram_we)
            mem[bus.sram_addr] <= bus.sram_di;
        if (bus.sram_en) begin
            a1 = bus.sram_addr + 12'd1;
            for (int j = 0; j < 4; j++) begin
                bus.sram_do[j]   <= mem[bus.sram_addr][8*j +: 8];
                bus.sram_do[j+4] <= mem[a1][8*j +: 8];
            end
        end
    end

    function automatic logic [31:0] word(input int k);
        return 32'h03020100 + 32'(k) * 32'h04040404;
    endfunction

    function automatic logic [63:0] expd(input int a);
        logic [63:0] r;
        for (int j = 0; j < 8; j++)
            r[8*j +: 8] = 8'(4 * a + j);
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h",
                    tag, obs, exp);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        int hs;
        int wc;
        bit got_done;

        RST = 1'b1;
        start = 1'b0;
        load_base = '0;
        load_len = '0;
        rd_base = '0;
        rd_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < 8; j++)
            bus.sram_do[j] = '0;

        step();
        step();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_en", bus.sram_en, 0);
        chk("rst_we", bus.sram_we, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_di", bus.sram_di, 0);
        chk("rst_out_valid", bus.out_valid, 0);

        // Load 16 words then read 4.
        step();
        RST = 1'b0;
        step();
        start = 1'b1;
        load_base = 12'd0;
        load_len = 13'd16;
        rd_base = 12'd0;
        rd_len = 13'd4;
        bus.out_ready = 1'b1;
        #1;
        chk("lr_idle_busy", busy, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            start = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data = word(k);
            #1;
            chk("lr_in_ready", bus.in_ready, 1);
            chk("lr_we", bus.sram_we, 1);
            chk("lr_en", bus.sram_en, 0);
            chk("lr_waddr", bus.sram_addr, 64'(k));
            chk("lr_di", bus.sram_di, word(k));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            bus.in_valid = 1'b0;
            #1;
            chk("lr_rd_in_ready", bus.in_ready, 0);
            chk("lr_rd_en", bus.sram_en, 1);
            chk("lr_rd_we", bus.sram_we, 0);
            chk("lr_raddr", bus.sram_addr, 64'(i));
            chk("lr_ov", bus.out_valid, 64'(i > 0));
            if (i > 0)
                chk("lr_data", bus.out_data, expd(i - 1));
        end
        step();
        #1;
        chk("lr_drain_en", bus.sram_en, 0);
        chk("lr_drain_ov", bus.out_valid, 1);
        chk("lr_drain_data", bus.out_data, expd(3));
        chk("lr_drain_done", done, 0);
        step();
        #1;
        chk("lr_drain2_ov", bus.out_valid, 0);
        chk("lr_drain2_done", done, 0);
        step();
        #1;
        chk("lr_done", done, 1);
        chk("lr_done_busy", busy, 1);
        step();
        #1;
        chk("lr_idle_done", done, 0);
        chk("lr_idle_busy2", busy, 0);

        // Backpressure on an 8-read run.
        step();
        start = 1'b1;
        load_len = 13'd0;
        rd_base = 12'd0;
        rd_len = 13'd8;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("bp_issue0_en", bus.sram_en, 1);
        chk("bp_issue0_addr", bus.sram_addr, 0);
        chk("bp_issue0_ov", bus.out_valid, 0);
        for (int s = 0; s < 5; s++) begin
            step();
            bus.out_ready = 1'b0;
            #1;
            chk("bp_stall_en", bus.sram_en, 0);
            chk("bp_stall_ov", bus.out_valid, 1);
            chk("bp_stall_data", bus.out_data, expd(0));
        end
        hs = 0;
        got_done = 1'b0;
        for (int c = 0; c < 30 && !got_done; c++) begin
            step();
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                chk("bp_hs_data", bus.out_data, expd(hs));
                hs++;
            end
            chk("bp_en_we", bus.sram_en & bus.sram_we, 0);
            if (done)
                got_done = 1'b1;
        end
        chk("bp_handshakes", 64'(hs), 8);
        chk("bp_done_seen", 64'(got_done), 1);

        // Input bubbles, 5 words at base 100.
        step();
        start = 1'b1;
        load_base = 12'd100;
        load_len = 13'd5;
        rd_len = 13'd0;
        wc = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            start = 1'b0;
            bus.in_valid = (c % 2 == 0);
            bus.in_data = 32'hA5A50000 + 32'(c);
            #1;
            chk("bub_we", bus.sram_we, 64'(bus.in_valid));
            if (bus.sram_we) begin
                chk("bub_addr", bus.sram_addr, 64'(100 + wc));
                wc++;
            end
        end
        step();
        bus.in_valid = 1'b1;
        #1;
        chk("bub_after_we", bus.sram_we, 0);
        chk("bub_after_ready", bus.in_ready, 0);
        chk("bub_done", done, 1);
        chk("bub_writes", 64'(wc), 5);
        step();
        bus.in_valid = 1'b0;

        // Write address wrap at the top of memory.
        step();
        start = 1'b1;
        load_base = 12'd4094;
        load_len = 13'd4;
        rd_len = 13'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            start = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data = word((k + 4094) % 4096);
            #1;
            chk("wrap_we", bus.sram_we, 1);
            chk("wrap_addr", bus.sram_addr,
                64'((4094 + k) % 4096));
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("wrap_done", done, 1);

        // Zero lengths, then a start during LOAD.
        step();
        start = 1'b1;
        load_len = 13'd0;
        rd_len = 13'd0;
        step();
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_en", bus.sram_en, 0);
        chk("zero_we", bus.sram_we, 0);
        step();
        #1;
        chk("zero_idle_done", done, 0);
        chk("zero_idle_busy", busy, 0);
        step();
        start = 1'b1;
        load_base = 12'd10;
        load_len = 13'd2;
        step();
        load_base = 12'd50;
        load_len = 13'd7;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h11111111;
        #1;
        chk("ign_addr0", bus.sram_addr, 10);
        step();
        start = 1'b0;
        #1;
        chk("ign_addr1", bus.sram_addr, 11);
        chk("ign_we1", bus.sram_we, 1);
        step();
        #1;
        chk("ign_in_ready", bus.in_ready, 0);
        chk("ign_done", done, 1);
        step();
        bus.in_valid = 1'b0;

        // Reset during a stalled READ.
        step();
        start = 1'b1;
        load_len = 13'd0;
        rd_base = 12'd2;
        rd_len = 13'd4;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        #1;
        chk("mr_issue_addr", bus.sram_addr, 2);
        step();
        RST = 1'b1;
        #1;
        chk("mr_pre_ov", bus.out_valid, 1);
        step();
        RST = 1'b0;
        #1;
        chk("mr_ov", bus.out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_en", bus.sram_en, 0);
        chk("mr_addr", bus.sram_addr, 0);
        chk("mr_done", done, 0);
        step();
        start = 1'b1;
        rd_base = 12'd2;
        rd_len = 13'd1;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("mr2_en", bus.sram_en, 1);
        chk("mr2_addr", bus.sram_addr, 2);
        step();
        #1;
        chk("mr2_ov", bus.out_valid, 1);
        chk("mr2_data", bus.out_data, expd(2));
        step();
        #1;
        chk("mr2_drain_ov", bus.out_valid, 0);
        step();
        #1;
        chk("mr2_done", done, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
